// File: rtl/wb_write_arbiter_if.sv
// Bundle of the dual-lane write-back inputs, register-file write port and forwarding lookup
// used by wb_write_arbiter. The master side is the pipeline/regfile, the slave side is the arbiter.
`ifndef AWIDTH
`define AWIDTH 5
`endif
`ifndef DWIDTH
`define DWIDTH 32
`endif

interface wb_write_arbiter_if;
  logic               wa_i_valid_a;
  logic [`AWIDTH-1:0] wa_i_addr_a;
  logic [`DWIDTH-1:0] wa_i_data_a;
  logic               wa_i_valid_b;
  logic [`AWIDTH-1:0] wa_i_addr_b;
  logic [`DWIDTH-1:0] wa_i_data_b;
  logic               wa_o_ready;
  logic               wa_o_wr_en;
  logic [`AWIDTH-1:0] wa_o_addr_rd;
  logic [`DWIDTH-1:0] wa_o_data_rd;
  logic [`AWIDTH-1:0] wa_i_addr_q;
  logic               wa_o_hit;
  logic [`DWIDTH-1:0] wa_o_data_q;
  logic               wa_o_err;

  modport master (
    output wa_i_valid_a, wa_i_addr_a, wa_i_data_a,
    output wa_i_valid_b, wa_i_addr_b, wa_i_data_b,
    output wa_i_addr_q,
    input  wa_o_ready, wa_o_wr_en, wa_o_addr_rd, wa_o_data_rd,
    input  wa_o_hit, wa_o_data_q, wa_o_err
  );

  modport slave (
    input  wa_i_valid_a, wa_i_addr_a, wa_i_data_a,
    input  wa_i_valid_b, wa_i_addr_b, wa_i_data_b,
    input  wa_i_addr_q,
    output wa_o_ready, wa_o_wr_en, wa_o_addr_rd, wa_o_data_rd,
    output wa_o_hit, wa_o_data_q, wa_o_err
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// Write-back arbiter: queues up to two results per cycle in program order and drains one per
// cycle into the register file write port, with a youngest-first forwarding lookup.
`ifndef AWIDTH
`define AWIDTH 5
`endif
`ifndef DWIDTH
`define DWIDTH 32
`endif

module wb_write_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic            wa_clk,
  input  logic            wa_rst,
  wb_write_arbiter_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [`AWIDTH-1:0] addr_mem [DEPTH];
  logic [`DWIDTH-1:0] data_mem [DEPTH];
  logic [PW-1:0]      head;
  logic [PW-1:0]      tail;
  logic [CW-1:0]      count;
  logic               ready;

  logic               pop;
  logic               load;
  logic [`AWIDTH-1:0] load_addr;
  logic [`DWIDTH-1:0] load_data;
  logic               push0_en;
  logic [`AWIDTH-1:0] push0_addr;
  logic [`DWIDTH-1:0] push0_data;
  logic               push1_en;
  logic               overflow;
  logic [CW-1:0]      n_push;

  // Ready only looks at the registered count so it never depends on this cycle's pop.
  assign ready          = (CW'(DEPTH) - count) >= CW'(2);
  assign bus.wa_o_ready = ready;

  // A non-empty queue always drains its head first; an empty one lets the oldest lane bypass.
  always_comb begin
    pop        = 1'b0;
    load       = 1'b0;
    load_addr  = bus.wa_o_addr_rd;
    load_data  = bus.wa_o_data_rd;
    push0_en   = 1'b0;
    push0_addr = bus.wa_i_addr_a;
    push0_data = bus.wa_i_data_a;
    push1_en   = 1'b0;
    overflow   = 1'b0;
    if (count != '0) begin
      pop       = 1'b1;
      load      = 1'b1;
      load_addr = addr_mem[head];
      load_data = data_mem[head];
    end
    if (!ready) begin
      overflow = bus.wa_i_valid_a | bus.wa_i_valid_b;
    end else if (count != '0) begin
      if (bus.wa_i_valid_a) begin
        push0_en = 1'b1;
        push1_en = bus.wa_i_valid_b;
      end else if (bus.wa_i_valid_b) begin
        push0_en   = 1'b1;
        push0_addr = bus.wa_i_addr_b;
        push0_data = bus.wa_i_data_b;
      end
    end else if (bus.wa_i_valid_a) begin
      load       = 1'b1;
      load_addr  = bus.wa_i_addr_a;
      load_data  = bus.wa_i_data_a;
      push0_en   = bus.wa_i_valid_b;
      push0_addr = bus.wa_i_addr_b;
      push0_data = bus.wa_i_data_b;
    end else if (bus.wa_i_valid_b) begin
      load      = 1'b1;
      load_addr = bus.wa_i_addr_b;
      load_data = bus.wa_i_data_b;
    end
  end

  assign n_push = CW'(push0_en) + CW'(push1_en);

  always_ff @(posedge wa_clk or negedge wa_rst) begin
    if (!wa_rst) begin
      count            <= '0;
      head             <= '0;
      tail             <= '0;
      bus.wa_o_wr_en   <= 1'b0;
      bus.wa_o_addr_rd <= '0;
      bus.wa_o_data_rd <= '0;
      bus.wa_o_err     <= 1'b0;
    end else begin
      count          <= count - CW'(pop) + n_push;
      head           <= head + PW'(pop);
      tail           <= tail + PW'(n_push);
      bus.wa_o_wr_en <= load;
      if (load) begin
        bus.wa_o_addr_rd <= load_addr;
        bus.wa_o_data_rd <= load_data;
      end
      if (overflow) begin
        bus.wa_o_err <= 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only ever read when count says they are live.
  always_ff @(posedge wa_clk) begin
    if (push0_en) begin
      addr_mem[tail] <= push0_addr;
      data_mem[tail] <= push0_data;
    end
    if (push1_en) begin
      addr_mem[tail + PW'(1)] <= bus.wa_i_addr_b;
      data_mem[tail + PW'(1)] <= bus.wa_i_data_b;
    end
  end

  // Oldest-to-youngest scan where later matches overwrite earlier ones, so the youngest wins.
  always_comb begin
    bus.wa_o_hit    = 1'b0;
    bus.wa_o_data_q = '0;
    if (bus.wa_o_wr_en && (bus.wa_o_addr_rd == bus.wa_i_addr_q)) begin
      bus.wa_o_hit    = 1'b1;
      bus.wa_o_data_q = bus.wa_o_data_rd;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count) && (addr_mem[head + PW'(i)] == bus.wa_i_addr_q)) begin
        bus.wa_o_hit    = 1'b1;
        bus.wa_o_data_q = data_mem[head + PW'(i)];
      end
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: a table of per-cycle vectors plus hand sequences for
// reset mid-drain and register-file commit ordering.
`ifndef AWIDTH
`define AWIDTH 5
`endif
`ifndef DWIDTH
`define DWIDTH 32
`endif

module tb_wb_write_arbiter;

  typedef struct {
    logic               va;
    logic [`AWIDTH-1:0] aa;
    logic [`DWIDTH-1:0] da;
    logic               vb;
    logic [`AWIDTH-1:0] ab;
    logic [`DWIDTH-1:0] db;
    logic [`AWIDTH-1:0] q;
    logic               wr;
    logic [`AWIDTH-1:0] ard;
    logic [`DWIDTH-1:0] drd;
    logic               rdy;
    logic               hit;
    logic [`DWIDTH-1:0] dq;
    logic               err;
  } vec_t;

  logic wa_clk = 1'b0;
  logic wa_rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [`DWIDTH-1:0] regs [32];
  vec_t vecs [17];

  wb_write_arbiter_if bus ();

  wb_write_arbiter #(.DEPTH(4)) dut (
    .wa_clk (wa_clk),
    .wa_rst (wa_rst),
    .bus    (bus.slave)
  );

  always #5 wa_clk = ~wa_clk;

  // Register file model commits on the negedge, as the real one does.
  always @(negedge wa_clk) begin
    if (bus.wa_o_wr_en) regs[bus.wa_o_addr_rd] <= bus.wa_o_data_rd;
  end

  function automatic vec_t mk(
    input logic va, input logic [`AWIDTH-1:0] aa, input logic [`DWIDTH-1:0] da,
    input logic vb, input logic [`AWIDTH-1:0] ab, input logic [`DWIDTH-1:0] db,
    input logic [`AWIDTH-1:0] q,
    input logic wr, input logic [`AWIDTH-1:0] ard, input logic [`DWIDTH-1:0] drd,
    input logic rdy, input logic hit, input logic [`DWIDTH-1:0] dq, input logic err);
    vec_t v;
    v.va = va; v.aa = aa; v.da = da; v.vb = vb; v.ab = ab; v.db = db; v.q = q;
    v.wr = wr; v.ard = ard; v.drd = drd; v.rdy = rdy; v.hit = hit; v.dq = dq; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [`DWIDTH-1:0] act,
                       input logic [`DWIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic va, input logic [`AWIDTH-1:0] aa,
                                input logic [`DWIDTH-1:0] da, input logic vb,
                                input logic [`AWIDTH-1:0] ab, input logic [`DWIDTH-1:0] db,
                                input logic [`AWIDTH-1:0] q);
    bus.wa_i_valid_a = va;
    bus.wa_i_addr_a  = aa;
    bus.wa_i_data_a  = da;
    bus.wa_i_valid_b = vb;
    bus.wa_i_addr_b  = ab;
    bus.wa_i_data_b  = db;
    bus.wa_i_addr_q  = q;
  endtask

  task automatic check_output(input string tag, input vec_t v);
    check({tag, " wr_en"},   `DWIDTH'(bus.wa_o_wr_en), `DWIDTH'(v.wr));
    check({tag, " addr_rd"}, `DWIDTH'(bus.wa_o_addr_rd), `DWIDTH'(v.ard));
    check({tag, " data_rd"}, bus.wa_o_data_rd, v.drd);
    check({tag, " ready"},   `DWIDTH'(bus.wa_o_ready), `DWIDTH'(v.rdy));
    check({tag, " hit"},     `DWIDTH'(bus.wa_o_hit), `DWIDTH'(v.hit));
    check({tag, " data_q"},  bus.wa_o_data_q, v.dq);
    check({tag, " err"},     `DWIDTH'(bus.wa_o_err), `DWIDTH'(v.err));
  endtask

  initial begin
    // Each row: lanes and query driven before an edge, outputs expected just after it.
    vecs[0]  = mk(0, 0, 0,     0, 0, 0,     0, 0, 0, 0,     1, 0, 0,     0);
    vecs[1]  = mk(1, 5, 'hAA,  0, 0, 0,     5, 1, 5, 'hAA,  1, 1, 'hAA,  0);
    vecs[2]  = mk(0, 0, 0,     0, 0, 0,     5, 0, 5, 'hAA,  1, 0, 0,     0);
    vecs[3]  = mk(1, 3, 'h11,  1, 3, 'h22,  3, 1, 3, 'h11,  1, 1, 'h22,  0);
    vecs[4]  = mk(0, 0, 0,     0, 0, 0,     3, 1, 3, 'h22,  1, 1, 'h22,  0);
    vecs[5]  = mk(0, 0, 0,     0, 0, 0,     3, 0, 3, 'h22,  1, 0, 0,     0);
    vecs[6]  = mk(0, 0, 0,     1, 9, 'h99,  9, 1, 9, 'h99,  1, 1, 'h99,  0);
    vecs[7]  = mk(1, 7, 'h10,  1, 7, 'h20,  7, 1, 7, 'h10,  1, 1, 'h20,  0);
    vecs[8]  = mk(0, 0, 0,     0, 0, 0,     8, 1, 7, 'h20,  1, 0, 0,     0);
    vecs[9]  = mk(0, 0, 0,     0, 0, 0,     7, 0, 7, 'h20,  1, 0, 0,     0);
    vecs[10] = mk(1, 1, 'hA1,  1, 2, 'hB2,  1, 1, 1, 'hA1,  1, 1, 'hA1,  0);
    vecs[11] = mk(1, 3, 'hA3,  1, 4, 'hB4,  2, 1, 2, 'hB2,  1, 1, 'hB2,  0);
    vecs[12] = mk(1, 5, 'hA5,  1, 6, 'hB6,  3, 1, 3, 'hA3,  0, 1, 'hA3,  0);
    vecs[13] = mk(1, 8, 'h88,  0, 0, 0,     8, 1, 4, 'hB4,  1, 0, 0,     1);
    vecs[14] = mk(0, 0, 0,     0, 0, 0,     6, 1, 5, 'hA5,  1, 1, 'hB6,  1);
    vecs[15] = mk(0, 0, 0,     0, 0, 0,     5, 1, 6, 'hB6,  1, 0, 0,     1);
    vecs[16] = mk(0, 0, 0,     0, 0, 0,     6, 0, 6, 'hB6,  1, 0, 0,     1);

    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    #12;
    check("reset wr_en", `DWIDTH'(bus.wa_o_wr_en), 0);
    check("reset ready", `DWIDTH'(bus.wa_o_ready), 1);
    check("reset hit",   `DWIDTH'(bus.wa_o_hit), 0);
    check("reset err",   `DWIDTH'(bus.wa_o_err), 0);
    @(negedge wa_clk);
    wa_rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      @(negedge wa_clk);
      apply_stimulus(vecs[i].va, vecs[i].aa, vecs[i].da, vecs[i].vb, vecs[i].ab, vecs[i].db,
                     vecs[i].q);
      @(posedge wa_clk);
      #1;
      check_output($sformatf("v%0d", i), vecs[i]);
    end

    // Build up three pending writes, then reset in the middle of the drain.
    for (int i = 0; i < 3; i++) begin
      @(negedge wa_clk);
      apply_stimulus(1, `AWIDTH'(10 + 2 * i), `DWIDTH'(i + 1),
                     1, `AWIDTH'(11 + 2 * i), `DWIDTH'(i + 1), 0);
      @(posedge wa_clk);
    end
    #1;
    check("fill ready low", `DWIDTH'(bus.wa_o_ready), 0);
    @(negedge wa_clk);
    apply_stimulus(0, 0, 0, 0, 0, 0, 13);
    #1 wa_rst = 1'b0;
    #1;
    check("midreset wr_en",   `DWIDTH'(bus.wa_o_wr_en), 0);
    check("midreset addr_rd", `DWIDTH'(bus.wa_o_addr_rd), 0);
    check("midreset data_rd", bus.wa_o_data_rd, 0);
    check("midreset ready",   `DWIDTH'(bus.wa_o_ready), 1);
    check("midreset err",     `DWIDTH'(bus.wa_o_err), 0);
    check("midreset hit",     `DWIDTH'(bus.wa_o_hit), 0);
    @(negedge wa_clk);
    wa_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge wa_clk);
      #1;
      check($sformatf("post-reset idle%0d wr_en", i), `DWIDTH'(bus.wa_o_wr_en), 0);
    end

    // Bypass write lands in the register file at the following negedge, for one cycle only.
    @(negedge wa_clk);
    apply_stimulus(1, 5, 'hAA, 0, 0, 0, 0);
    @(posedge wa_clk);
    #1;
    check("bypass wr_en", `DWIDTH'(bus.wa_o_wr_en), 1);
    @(negedge wa_clk);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("bypass reg5", regs[5], 'hAA);
    @(posedge wa_clk);
    #1;
    check("bypass one cycle", `DWIDTH'(bus.wa_o_wr_en), 0);

    // Same destination on both lanes: A commits first, B's value is what remains.
    @(negedge wa_clk);
    apply_stimulus(1, 3, 'h11, 1, 3, 'h22, 0);
    @(posedge wa_clk);
    @(negedge wa_clk);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("dual reg3 first", regs[3], 'h11);
    @(posedge wa_clk);
    @(negedge wa_clk);
    #1;
    check("dual reg3 final", regs[3], 'h22);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
